// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer controller.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Bit positions of each button in the packed button vector
  localparam int NUM_BTN   = 4;
  localparam int BTN_START = 0;
  localparam int BTN_RESET = 1;
  localparam int BTN_SEC   = 2;
  localparam int BTN_MIN   = 3;

  // Shared auto-repeat counter width; holds the 25 M default delay
  localparam int REP_W     = 25;

  // Edges from a button falling to its strobe appearing (2 sync + 1 output)
  localparam int PRESS_LAT = 3;

endpackage

// File: rtl/btn_edge.sv
// Per-button front end: 2-flop synchronizer plus falling-edge detect.
// The synchronizer flops preset to 1 so a reset never creates a fake press.
module btn_edge (
  input  logic MCLK,
  input  logic RST_N,
  input  logic btn_n,
  output logic lvl_n,
  output logic press
);

  logic s1, s2, s3;

  // Synchronize the async button, keep one extra stage for edge detect
  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= btn_n;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign lvl_n = s2;
  assign press = s3 & ~s2;

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer sequencing controller: IDLE/RUN/PAUSE/DONE FSM driving
// one-cycle strobes into the BCD counter chain and the DP blink.
// Optional feature macro: TIMER_CTRL_AUTOREPEAT_EN (sec/min auto-repeat in IDLE).
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
  input  logic MCLK,
  input  logic RST_N,
  input  logic BTN_START_N,
  input  logic BTN_RESET_N,
  input  logic BTN_SEC_N,
  input  logic BTN_MIN_N,
  input  logic TICK_1HZ,
  input  logic ZERO,
  output logic CNT_CLR,
  output logic CNT_INC_SEC,
  output logic CNT_INC_MIN,
  output logic CNT_DEC,
  output logic RUNNING,
  output logic ENDED,
  output logic BLINK_DP
);

  logic [NUM_BTN-1:0] btn_n, lvl_n, press;

  assign btn_n[BTN_START] = BTN_START_N;
  assign btn_n[BTN_RESET] = BTN_RESET_N;
  assign btn_n[BTN_SEC]   = BTN_SEC_N;
  assign btn_n[BTN_MIN]   = BTN_MIN_N;

  btn_edge u_btn [NUM_BTN-1:0] (
    .MCLK  (MCLK),
    .RST_N (RST_N),
    .btn_n (btn_n),
    .lvl_n (lvl_n),
    .press (press)
  );

  // Start/reset levels are only needed as edges
  logic unused_lvl;
  assign unused_lvl = ^lvl_n;

  state_e state, nxt;
  logic   phase, phase_nxt;
  logic   rep_fire, rep_min;

`ifdef TIMER_CTRL_AUTOREPEAT_EN
  localparam logic [REP_W-1:0] DLY_END = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PER_END = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_first, held, rep_hit;

  assign held     = (state == IDLE) && !(lvl_n[BTN_SEC] && lvl_n[BTN_MIN]);
  assign rep_hit  = held && (rep_first ? (rep_cnt == DLY_END) : (rep_cnt == PER_END));
  assign rep_fire = rep_hit && !(|press);
  assign rep_min  = !lvl_n[BTN_MIN];

  // Repeat timer; seeded with the press latency on a press event so the
  // delay is measured from the physical button fall
  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (|press || !held) begin
      rep_cnt   <= (|press) ? REP_W'(PRESS_LAT) : '0;
      rep_first <= 1'b1;
    end else if (rep_hit) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else begin
      rep_cnt   <= rep_cnt + 1'b1;
    end
  end
`else
  assign rep_fire = 1'b0;
  assign rep_min  = 1'b0;

  logic unused_rep_cfg;
  assign unused_rep_cfg = (REPEAT_DELAY == REPEAT_PERIOD);
`endif

  logic clr, inc_s, inc_m, dec;

  // Next state and strobes; priority reset > start > min > sec
  always_comb begin
    nxt   = state;
    clr   = 1'b0;
    inc_s = 1'b0;
    inc_m = 1'b0;
    dec   = 1'b0;
    case (state)
      IDLE: begin
        if (press[BTN_RESET])      clr = 1'b1;
        else if (press[BTN_START]) begin
          if (!ZERO) nxt = RUN;
        end
        else if (press[BTN_MIN])   inc_m = 1'b1;
        else if (press[BTN_SEC])   inc_s = 1'b1;
        else if (rep_fire) begin
          inc_m = rep_min;
          inc_s = !rep_min;
        end
      end
      RUN: begin
        // ZERO wins over a tick so 00:00 never underflows
        if (ZERO) nxt = DONE;
        else begin
          dec = TICK_1HZ;
          if (press[BTN_START]) nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (press[BTN_RESET]) begin
          clr = 1'b1;
          nxt = IDLE;
        end else if (press[BTN_START]) nxt = RUN;
      end
      DONE: begin
        if (press[BTN_RESET]) begin
          clr = 1'b1;
          nxt = IDLE;
        end else if (press[BTN_START]) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase

    // Blink phase: set on DONE entry, toggles on ticks in DONE, 0 elsewhere
    phase_nxt = 1'b0;
    if (nxt == DONE) phase_nxt = (state != DONE) ? 1'b1 : (phase ^ TICK_1HZ);
  end

  // State and registered outputs
  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      phase       <= 1'b0;
      CNT_CLR     <= 1'b0;
      CNT_INC_SEC <= 1'b0;
      CNT_INC_MIN <= 1'b0;
      CNT_DEC     <= 1'b0;
      RUNNING     <= 1'b0;
      ENDED       <= 1'b0;
    end else begin
      state       <= nxt;
      phase       <= phase_nxt;
      CNT_CLR     <= clr;
      CNT_INC_SEC <= inc_s;
      CNT_INC_MIN <= inc_m;
      CNT_DEC     <= dec;
      RUNNING     <= (nxt == RUN);
      ENDED       <= (nxt == DONE);
    end
  end

  // phase is only ever 1 while in DONE, so it already equals ENDED & phase
  assign BLINK_DP = phase;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed, table-driven bench for timer_ctrl.
module tb_timer_ctrl;

  logic MCLK = 1'b0;
  logic RST_N;
  logic BTN_START_N, BTN_RESET_N, BTN_SEC_N, BTN_MIN_N;
  logic TICK_1HZ, ZERO;
  logic CNT_CLR, CNT_INC_SEC, CNT_INC_MIN, CNT_DEC, RUNNING, ENDED, BLINK_DP;

  always #5 MCLK = ~MCLK;

  timer_ctrl #(.REPEAT_DELAY(20), .REPEAT_PERIOD(5)) dut (
    .MCLK        (MCLK),
    .RST_N       (RST_N),
    .BTN_START_N (BTN_START_N),
    .BTN_RESET_N (BTN_RESET_N),
    .BTN_SEC_N   (BTN_SEC_N),
    .BTN_MIN_N   (BTN_MIN_N),
    .TICK_1HZ    (TICK_1HZ),
    .ZERO        (ZERO),
    .CNT_CLR     (CNT_CLR),
    .CNT_INC_SEC (CNT_INC_SEC),
    .CNT_INC_MIN (CNT_INC_MIN),
    .CNT_DEC     (CNT_DEC),
    .RUNNING     (RUNNING),
    .ENDED       (ENDED),
    .BLINK_DP    (BLINK_DP)
  );

  // Output vector order: {CLR, INC_SEC, INC_MIN, DEC, RUNNING, ENDED, BLINK}
  localparam logic [6:0] O_CLR = 7'b1000000, O_ISEC = 7'b0100000, O_IMIN = 7'b0010000,
                         O_DEC = 7'b0001000, O_RUN  = 7'b0000100, O_END  = 7'b0000010,
                         O_BLK = 7'b0000001;
  // Active-low button masks {min, sec, reset, start}
  localparam logic [3:0] B_REL = 4'b1111, B_START = 4'b1110, B_RST = 4'b1101,
                         B_SEC = 4'b1011, B_MIN = 4'b0111, B_RSTMIN = 4'b0101;

  typedef struct {
    logic [3:0] btn_n;
    logic       tick;
    logic       zero;
    logic [6:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [6:0] outs();
    return {CNT_CLR, CNT_INC_SEC, CNT_INC_MIN, CNT_DEC, RUNNING, ENDED, BLINK_DP};
  endfunction

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] b, input logic t, input logic z,
                     input logic [6:0] e, input string nm);
    vec_t v;
    v.btn_n = b; v.tick = t; v.zero = z; v.exp = e; v.name = nm;
    tbl.push_back(v);
  endtask

  // One press: held three edges (effect shows after the third), then released
  task automatic grp(input logic [3:0] b, input logic z, input logic [6:0] e12,
                     input logic [6:0] e3, input logic [6:0] e4, input string nm);
    add(b, 1'b0, z, e12, {nm, "_lat1"});
    add(b, 1'b0, z, e12, {nm, "_lat2"});
    add(b, 1'b0, z, e3,  nm);
    add(B_REL, 1'b0, z, e4, {nm, "_after"});
  endtask

  task automatic drive(input logic [3:0] b, input logic t, input logic z);
    {BTN_MIN_N, BTN_SEC_N, BTN_RESET_N, BTN_START_N} = b;
    TICK_1HZ = t;
    ZERO     = z;
  endtask

  initial begin
    // IDLE: three sec presses, two min presses
    for (int i = 0; i < 3; i++) grp(B_SEC, 1'b0, '0, O_ISEC, '0, "idle_sec");
    for (int i = 0; i < 2; i++) grp(B_MIN, 1'b0, '0, O_IMIN, '0, "idle_min");
    // start with ZERO=1 ignored, then ZERO=0 starts
    grp(B_START, 1'b1, '0, '0, '0, "start_at_zero");
    grp(B_START, 1'b0, '0, O_RUN, O_RUN, "start_run");
    // five ticks in RUN
    for (int i = 0; i < 5; i++) begin
      add(B_REL, 1'b1, 1'b0, O_DEC | O_RUN, "run_tick");
      add(B_REL, 1'b0, 1'b0, O_RUN, "run_tick_gap");
    end
    // ZERO with a tick: DONE, no decrement, blink phase toggles with ticks
    add(B_REL, 1'b1, 1'b1, O_END | O_BLK, "zero_tick_done");
    add(B_REL, 1'b0, 1'b1, O_END | O_BLK, "done_hold");
    add(B_REL, 1'b1, 1'b1, O_END, "done_blink_off");
    add(B_REL, 1'b0, 1'b1, O_END, "done_blink_hold");
    add(B_REL, 1'b1, 1'b1, O_END | O_BLK, "done_blink_on");
    grp(B_START, 1'b1, O_END | O_BLK, '0, '0, "done_start_idle");
    // start press coinciding with a tick in RUN
    grp(B_START, 1'b0, '0, O_RUN, O_RUN, "start_run2");
    add(B_START, 1'b0, 1'b0, O_RUN, "pause_lat1");
    add(B_START, 1'b0, 1'b0, O_RUN, "pause_lat2");
    add(B_START, 1'b1, 1'b0, O_DEC, "start_and_tick");
    add(B_REL,   1'b0, 1'b0, '0, "pause_settle");
    add(B_REL,   1'b1, 1'b0, '0, "pause_tick_ignored");
    grp(B_SEC, 1'b0, '0, '0, '0, "pause_sec_ignored");
    grp(B_RST, 1'b0, '0, O_CLR, '0, "pause_reset");
    grp(B_SEC, 1'b0, '0, O_ISEC, '0, "idle_after_clr");
    // reset/min ignored in RUN, ZERO without tick ends the run
    grp(B_START, 1'b0, '0, O_RUN, O_RUN, "start_run3");
    grp(B_RST, 1'b0, O_RUN, O_RUN, O_RUN, "run_reset_ignored");
    grp(B_MIN, 1'b0, O_RUN, O_RUN, O_RUN, "run_min_ignored");
    add(B_REL, 1'b0, 1'b1, O_END | O_BLK, "run_zero_done");
    grp(B_RST, 1'b1, O_END | O_BLK, O_CLR, '0, "done_reset");
    // same-cycle reset and min press: only the clear
    grp(B_RSTMIN, 1'b0, '0, O_CLR, '0, "reset_min_same");
    // back into DONE for the async reset check
    grp(B_START, 1'b0, '0, O_RUN, O_RUN, "start_run4");
    add(B_REL, 1'b0, 1'b1, O_END | O_BLK, "run_zero_done2");

    // Reset state
    RST_N = 1'b0;
    drive(B_REL, 1'b0, 1'b0);
    #2;
    chk("reset_async", outs(), '0);
    repeat (3) @(posedge MCLK);
    #1;
    chk("reset_hold", outs(), '0);
    RST_N = 1'b1;

    // Table run: inputs set after sampling, checked 1 ns after the next edge
    foreach (tbl[i]) begin
      drive(tbl[i].btn_n, tbl[i].tick, tbl[i].zero);
      @(posedge MCLK);
      #1;
      chk(tbl[i].name, outs(), tbl[i].exp);
    end

    // RST_N mid-cycle in DONE clears all outputs without waiting for an edge
    drive(B_REL, 1'b0, 1'b1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("done_async_reset", outs(), '0);
    @(posedge MCLK);
    #1;
    chk("async_reset_hold", outs(), '0);
    RST_N = 1'b1;
    drive(B_REL, 1'b0, 1'b0);
    repeat (2) @(posedge MCLK);
    #1;

    // Sec held 36 cycles: one strobe, plus repeats when the feature is built in
    for (int k = 1; k <= 45; k++) begin
      logic e;
      drive((k <= 36) ? B_SEC : B_REL, 1'b0, 1'b0);
      @(posedge MCLK);
      #1;
`ifdef TIMER_CTRL_AUTOREPEAT_EN
      e = (k == 3) || (k == 20) || (k == 25) || (k == 30) || (k == 35);
`else
      e = (k == 3);
`endif
      chk($sformatf("sec_hold_c%0d", k), outs(), e ? O_ISEC : 7'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
